// File: rtl/rf_pkg.sv
// Shared types and defaults for the dual-write register file.
// Imported by the scoreboard, the register file top and the bench.
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: RAW detection on reads, destination reservation.
// Tracks the number of busy registers for issue throttling.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              wea_eff,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic              web_eff,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              alloc_ok,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic [ADDR_W:0] busy_cnt_q, busy_cnt_d;
  logic            alloc_zero, wr_hit, set_en;
  logic            inc, dec_a, dec_b;

  assign alloc_zero = (ZERO_REG != 0) && (alloc_addr == '0);
  assign wr_hit = (wea_eff && wa_a == alloc_addr)
               || (web_eff && wa_b == alloc_addr);
  assign alloc_ok = alloc_en
                 && (alloc_zero || !busy_q[alloc_addr] || wr_hit);
  assign set_en = alloc_ok && !alloc_zero;

  always_comb begin
    busy_d = busy_q;
    if (wea_eff) busy_d[wa_a] = 1'b0;
    if (web_eff) busy_d[wa_b] = 1'b0;
    if (set_en) busy_d[alloc_addr] = 1'b1;
  end

  // A bit re-set by the same-cycle alloc is not released; port B
  // only counts if it did not hit the same register as port A.
  assign inc = set_en && !busy_q[alloc_addr];
  assign dec_a = wea_eff && busy_q[wa_a]
              && !(set_en && alloc_addr == wa_a);
  assign dec_b = web_eff && busy_q[wa_b]
              && !(set_en && alloc_addr == wa_b)
              && !(wea_eff && wa_a == wa_b);

  assign busy_cnt_d = busy_cnt_q
                    + {{ADDR_W{1'b0}}, inc}
                    - {{ADDR_W{1'b0}}, dec_a}
                    - {{ADDR_W{1'b0}}, dec_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (int'(busy_cnt_q) <= NREG);
  end

  assign busy_cnt = busy_cnt_q;

  always_comb begin
    rd1_busy = busy_q[ra1];
    if (BYPASS != 0
        && ((wea_eff && wa_a == ra1) || (web_eff && wa_b == ra1)))
      rd1_busy = set_en && alloc_addr == ra1;
    if (ZERO_REG != 0 && ra1 == '0) rd1_busy = 1'b0;
  end

  always_comb begin
    rd2_busy = busy_q[ra2];
    if (BYPASS != 0
        && ((wea_eff && wa_a == ra2) || (web_eff && wa_b == ra2)))
      rd2_busy = set_en && alloc_addr == ra2;
    if (ZERO_REG != 0 && ra2 == '0) rd2_busy = 1'b0;
  end
endmodule

// File: rtl/reg_file_sb.sv
// 2R/2W register file with busy scoreboard for the dual-issue core.
// Port B has write priority; optional bypass and hardwired r0.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd1_busy,
  output logic              rd2_busy,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ok,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic              wea_eff, web_eff, wea_mem;

  assign wea_eff = we_a && !(ZERO_REG != 0 && wa_a == '0);
  assign web_eff = we_b && !(ZERO_REG != 0 && wa_b == '0);
  assign wea_mem = wea_eff && !(web_eff && wa_a == wa_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      if (wea_mem) mem_q[wa_a] <= wd_a;
      if (web_eff) mem_q[wa_b] <= wd_b;
    end
  end

  always_comb begin
    rd1 = mem_q[ra1];
    if (BYPASS != 0) begin
      if (web_eff && wa_b == ra1) rd1 = wd_b;
      else if (wea_eff && wa_a == ra1) rd1 = wd_a;
    end
    if (ZERO_REG != 0 && ra1 == '0) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (BYPASS != 0) begin
      if (web_eff && wa_b == ra2) rd2 = wd_b;
      else if (wea_eff && wa_a == ra2) rd2 = wd_a;
    end
    if (ZERO_REG != 0 && ra2 == '0) rd2 = '0;
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra1       (ra1),
    .ra2       (ra2),
    .wea_eff   (wea_eff),
    .wa_a      (wa_a),
    .web_eff   (web_eff),
    .wa_b      (wa_b),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .rd1_busy  (rd1_busy),
    .rd2_busy  (rd2_busy),
    .alloc_ok  (alloc_ok),
    .busy_cnt  (busy_cnt)
  );
endmodule
